// File: rtl/tree_filler_mc_if.sv
// Request, line-refill and record-return signals between the loader/tree and tree_filler_mc.
interface tree_filler_mc_if #(
  parameter int W_LOG = 2,
  parameter int P_LOG = 3,
  parameter int DATW  = 64
);
  localparam int NCH   = 1 << W_LOG;
  localparam int LINEW = DATW << P_LOG;

  logic [W_LOG-1:0] I_REQUEST;
  logic             I_REQUEST_VALID;
  logic [LINEW-1:0] DIN;
  logic             DINEN;
  logic [W_LOG-1:0] WADDR;
  logic             QUEUE_FULL;
  logic [DATW-1:0]  DOT;
  logic             DOTEN;
  logic [W_LOG-1:0] DOT_IDX;
  logic [NCH-1:0]   EMP;
  logic [NCH-1:0]   FULL;
  logic             OVERFLOW;

  modport master (
    output I_REQUEST, I_REQUEST_VALID, DIN, DINEN, WADDR,
    input  QUEUE_FULL, DOT, DOTEN, DOT_IDX, EMP, FULL, OVERFLOW
  );
  modport slave (
    input  I_REQUEST, I_REQUEST_VALID, DIN, DINEN, WADDR,
    output QUEUE_FULL, DOT, DOTEN, DOT_IDX, EMP, FULL, OVERFLOW
  );
endinterface

// File: rtl/tree_filler_mc.sv
// Multi-channel tree filler: per-channel line rings in one BRAM, in-order request
// queue, one record issued per cycle with a 2-stage read/select pipeline.
module tree_filler_mc_chan #(
  parameter int P_LOG = 3,
  parameter int D_LOG = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             wr,
  input  logic             rd,
  output logic             emp,
  output logic             full,
  output logic [D_LOG-1:0] wline,
  output logic [D_LOG-1:0] rline,
  output logic [P_LOG-1:0] rec
);
  logic [D_LOG:0] wptr, rptr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr <= '0;
      rptr <= '0;
      rec  <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) begin
        rec <= rec + 1'b1;
        // last record of the line: release it
        if (&rec) rptr <= rptr + 1'b1;
      end
    end
  end

  assign emp   = (wptr == rptr);
  assign full  = (wptr[D_LOG-1:0] == rptr[D_LOG-1:0]) && (wptr[D_LOG] != rptr[D_LOG]);
  assign wline = wptr[D_LOG-1:0];
  assign rline = rptr[D_LOG-1:0];
endmodule

module tree_filler_mc #(
  parameter int W_LOG = 2,
  parameter int P_LOG = 3,
  parameter int D_LOG = 1,
  parameter int Q_LOG = 1,
  parameter int DATW  = 64
) (
  input logic          CLK,
  input logic          RST_N,
  tree_filler_mc_if.slave bus
);
  localparam int NCH    = 1 << W_LOG;
  localparam int LINEW  = DATW << P_LOG;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [W_LOG-1:0] ch;
    logic [P_LOG-1:0] rec;
  } iss_t;

  logic [NCH-1:0]            emp, full, wr_sel, rd_sel;
  logic [NCH-1:0][D_LOG-1:0] wline, rline;
  logic [NCH-1:0][P_LOG-1:0] rec;

  tree_filler_mc_chan #(.P_LOG(P_LOG), .D_LOG(D_LOG)) u_chan [NCH-1:0] (
    .CLK(CLK), .RST_N(RST_N), .wr(wr_sel), .rd(rd_sel),
    .emp(emp), .full(full), .wline(wline), .rline(rline), .rec(rec)
  );

  logic [(1<<Q_LOG)-1:0][W_LOG-1:0] q_mem;
  logic [Q_LOG:0]   q_wp, q_rp;
  logic [W_LOG-1:0] q_head;
  logic             q_empty, q_full, issue, push, wr_ok, ovf;

  assign q_head  = q_mem[q_rp[Q_LOG-1:0]];
  assign q_empty = (q_wp == q_rp);
  assign q_full  = (q_wp[Q_LOG] != q_rp[Q_LOG]) && (q_wp[Q_LOG-1:0] == q_rp[Q_LOG-1:0]);
  // empty head channel blocks everything behind it (strict in-order service)
  assign issue   = !q_empty && !emp[q_head];
  assign push    = bus.I_REQUEST_VALID && (!q_full || issue);
  assign wr_ok   = bus.DINEN && !full[bus.WADDR];
  assign wr_sel  = wr_ok ? (NCH'(1) << bus.WADDR) : '0;
  assign rd_sel  = issue ? (NCH'(1) << q_head) : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_mem <= '0;
      q_wp  <= '0;
      q_rp  <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) begin
        q_mem[q_wp[Q_LOG-1:0]] <= bus.I_REQUEST;
        q_wp <= q_wp + 1'b1;
      end
      if (issue) q_rp <= q_rp + 1'b1;
      if ((bus.DINEN && full[bus.WADDR]) || (bus.I_REQUEST_VALID && q_full && !issue))
        ovf <= 1'b1;
    end
  end

  // Line store; address is {channel, line}. A write never hits the line being
  // read because a full channel rejects writes.
  logic [LINEW-1:0] mem [NCH << D_LOG];
  logic [LINEW-1:0] rd_line;

  always_ff @(posedge CLK) begin
    if (wr_ok) mem[{bus.WADDR, wline[bus.WADDR]}] <= bus.DIN;
    if (issue) rd_line <= mem[{q_head, rline[q_head]}];
  end

  logic [STAGES:1]  vld_pipe;
  iss_t             s1;
  logic [W_LOG-1:0] ch2;
  logic [DATW-1:0]  dot_r;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe <= '0;
      s1       <= '0;
      ch2      <= '0;
      dot_r    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], issue};
      if (issue) s1 <= '{ch: q_head, rec: rec[q_head]};
      if (vld_pipe[1]) begin
        ch2   <= s1.ch;
        // low DATW bits of the line shifted right by DATW*rec
        dot_r <= rd_line[DATW*int'(s1.rec) +: DATW];
      end
    end
  end

  assign bus.QUEUE_FULL = q_full;
  assign bus.DOT        = dot_r;
  assign bus.DOTEN      = vld_pipe[STAGES];
  assign bus.DOT_IDX    = ch2;
  assign bus.EMP        = emp;
  assign bus.FULL       = full;
  assign bus.OVERFLOW   = ovf;
endmodule
